// File: rtl/ex_stage.sv
// Execute stage of the RV64 pipeline: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register, with flush turning the captured entry into a bubble.
module ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      ID_EX_Inst,
    input  logic [4:0]      ID_EX_rs1,
    input  logic [4:0]      ID_EX_rs2,
    input  logic [4:0]      ID_EX_rd,
    input  logic [XLEN-1:0] ID_EX_PC_Out,
    input  logic [XLEN-1:0] ID_EX_ReadData1,
    input  logic [XLEN-1:0] ID_EX_ReadData2,
    input  logic [XLEN-1:0] ID_EX_imm_data,
    input  logic [1:0]      ID_EX_ALUop,
    input  logic            ID_EX_ALUsrc,
    input  logic            ID_EX_Branch,
    input  logic            ID_EX_MemRead,
    input  logic            ID_EX_MemWrite,
    input  logic            ID_EX_RegWrite,
    input  logic            ID_EX_MemtoReg,
    input  logic [4:0]      MEM_WB_rd,
    input  logic            MEM_WB_RegWrite,
    input  logic [XLEN-1:0] MEM_WB_WriteData,
    input  logic            flush,
    output logic [XLEN-1:0] EX_MEM_ALU_Result,
    output logic            EX_MEM_Zero,
    output logic [XLEN-1:0] EX_MEM_WriteData,
    output logic [XLEN-1:0] EX_MEM_Branch_Target,
    output logic            EX_MEM_BranchTaken,
    output logic [4:0]      EX_MEM_rd,
    output logic            EX_MEM_MemRead,
    output logic            EX_MEM_MemWrite,
    output logic            EX_MEM_RegWrite,
    output logic            EX_MEM_MemtoReg
);

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctl_e;

    // x0 is hard-wired zero, so a write targeting it must never be forwarded
    function automatic logic fwd_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic alu_ctl_e alu_decode(input logic [1:0] op, input logic [3:0] inst);
        alu_ctl_e ctl;
        case (op)
            2'b00: ctl = ALU_ADD;
            2'b01: ctl = ALU_SUB;
            2'b10: begin
                case (inst)
                    4'b0000: ctl = ALU_ADD;
                    4'b1000: ctl = ALU_SUB;
                    4'b0111: ctl = ALU_AND;
                    4'b0110: ctl = ALU_OR;
                    default: ctl = ALU_ADD;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    function automatic logic [XLEN-1:0] alu_calc(input alu_ctl_e ctl,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (ctl)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        logic c;
        case (f3)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ($signed(a) < $signed(b));
            3'b101:  c = ($signed(a) >= $signed(b));
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] alu_b_s;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] br_target_s;
    logic            br_taken_s;

    // Operand forwarding: the EX/MEM entry (our own register) is younger than MEM/WB
    always_comb begin
        fwd_a_s = ID_EX_ReadData1;
        fwd_b_s = ID_EX_ReadData2;
        if (fwd_hit(EX_MEM_RegWrite, EX_MEM_rd, ID_EX_rs1)) begin
            fwd_a_s = EX_MEM_ALU_Result;
        end else if (fwd_hit(MEM_WB_RegWrite, MEM_WB_rd, ID_EX_rs1)) begin
            fwd_a_s = MEM_WB_WriteData;
        end else begin
            fwd_a_s = ID_EX_ReadData1;
        end
        if (fwd_hit(EX_MEM_RegWrite, EX_MEM_rd, ID_EX_rs2)) begin
            fwd_b_s = EX_MEM_ALU_Result;
        end else if (fwd_hit(MEM_WB_RegWrite, MEM_WB_rd, ID_EX_rs2)) begin
            fwd_b_s = MEM_WB_WriteData;
        end else begin
            fwd_b_s = ID_EX_ReadData2;
        end
    end

    // ALU, branch decision and branch target for the instruction in EX
    always_comb begin
        alu_b_s     = ID_EX_ALUsrc ? ID_EX_imm_data : fwd_b_s;
        alu_res_s   = alu_calc(alu_decode(ID_EX_ALUop, ID_EX_Inst), fwd_a_s, alu_b_s);
        br_taken_s  = ID_EX_Branch & branch_cond(ID_EX_Inst[2:0], fwd_a_s, fwd_b_s);
        br_target_s = ID_EX_PC_Out + (ID_EX_imm_data << 1);
    end

    // EX/MEM pipeline register; flush captures a full bubble (all fields zero)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            EX_MEM_ALU_Result    <= {XLEN{1'b0}};
            EX_MEM_Zero          <= 1'b0;
            EX_MEM_WriteData     <= {XLEN{1'b0}};
            EX_MEM_Branch_Target <= {XLEN{1'b0}};
            EX_MEM_BranchTaken   <= 1'b0;
            EX_MEM_rd            <= 5'd0;
            EX_MEM_MemRead       <= 1'b0;
            EX_MEM_MemWrite      <= 1'b0;
            EX_MEM_RegWrite      <= 1'b0;
            EX_MEM_MemtoReg      <= 1'b0;
        end else if (flush) begin
            EX_MEM_ALU_Result    <= {XLEN{1'b0}};
            EX_MEM_Zero          <= 1'b0;
            EX_MEM_WriteData     <= {XLEN{1'b0}};
            EX_MEM_Branch_Target <= {XLEN{1'b0}};
            EX_MEM_BranchTaken   <= 1'b0;
            EX_MEM_rd            <= 5'd0;
            EX_MEM_MemRead       <= 1'b0;
            EX_MEM_MemWrite      <= 1'b0;
            EX_MEM_RegWrite      <= 1'b0;
            EX_MEM_MemtoReg      <= 1'b0;
        end else begin
            EX_MEM_ALU_Result    <= alu_res_s;
            EX_MEM_Zero          <= (alu_res_s == {XLEN{1'b0}});
            EX_MEM_WriteData     <= fwd_b_s;
            EX_MEM_Branch_Target <= br_target_s;
            EX_MEM_BranchTaken   <= br_taken_s;
            EX_MEM_rd            <= ID_EX_rd;
            EX_MEM_MemRead       <= ID_EX_MemRead;
            EX_MEM_MemWrite      <= ID_EX_MemWrite;
            EX_MEM_RegWrite      <= ID_EX_RegWrite;
            EX_MEM_MemtoReg      <= ID_EX_MemtoReg;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a reference model pushes expected EX/MEM entries
// into a scoreboard queue at drive time; each scenario task pops and compares after the edge.
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  ID_EX_Inst;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [63:0] ID_EX_PC_Out, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_imm_data;
    logic [1:0]  ID_EX_ALUop;
    logic        ID_EX_ALUsrc, ID_EX_Branch, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_MemtoReg;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_RegWrite;
    logic [63:0] MEM_WB_WriteData;
    logic        flush;
    logic [63:0] EX_MEM_ALU_Result, EX_MEM_WriteData, EX_MEM_Branch_Target;
    logic        EX_MEM_Zero, EX_MEM_BranchTaken;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg;

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic [63:0] wd;
        logic [63:0] tgt;
        logic        taken;
        logic [4:0]  rd;
        logic [3:0]  ctl;   // {MemRead, MemWrite, RegWrite, MemtoReg}
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    exp_t e;
    exp_t got;
    int   n_checks;
    int   n_fail;

    logic [3:0]  rt_inst [4] = '{4'b0111, 4'b0110, 4'b1000, 4'b0000};
    logic [63:0] rt_res  [4] = '{64'h30, 64'hFC, 64'hB4, 64'h12C};

    assign got = {EX_MEM_ALU_Result, EX_MEM_Zero, EX_MEM_WriteData, EX_MEM_Branch_Target,
                  EX_MEM_BranchTaken, EX_MEM_rd, EX_MEM_MemRead, EX_MEM_MemWrite,
                  EX_MEM_RegWrite, EX_MEM_MemtoReg};

    ex_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .ID_EX_Inst(ID_EX_Inst), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_PC_Out(ID_EX_PC_Out), .ID_EX_ReadData1(ID_EX_ReadData1),
        .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_imm_data(ID_EX_imm_data),
        .ID_EX_ALUop(ID_EX_ALUop), .ID_EX_ALUsrc(ID_EX_ALUsrc), .ID_EX_Branch(ID_EX_Branch),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_WriteData(MEM_WB_WriteData), .flush(flush),
        .EX_MEM_ALU_Result(EX_MEM_ALU_Result), .EX_MEM_Zero(EX_MEM_Zero),
        .EX_MEM_WriteData(EX_MEM_WriteData), .EX_MEM_Branch_Target(EX_MEM_Branch_Target),
        .EX_MEM_BranchTaken(EX_MEM_BranchTaken), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour of one EX/MEM capture, using the bench's own view of EX/MEM
    function automatic exp_t model();
        exp_t m;
        logic [63:0] a, b, op2;
        logic c;
        m = '0;
        if (last_e.ctl[1] && last_e.rd != 5'd0 && last_e.rd == ID_EX_rs1) a = last_e.res;
        else if (MEM_WB_RegWrite && MEM_WB_rd != 5'd0 && MEM_WB_rd == ID_EX_rs1) a = MEM_WB_WriteData;
        else a = ID_EX_ReadData1;
        if (last_e.ctl[1] && last_e.rd != 5'd0 && last_e.rd == ID_EX_rs2) b = last_e.res;
        else if (MEM_WB_RegWrite && MEM_WB_rd != 5'd0 && MEM_WB_rd == ID_EX_rs2) b = MEM_WB_WriteData;
        else b = ID_EX_ReadData2;
        op2 = ID_EX_ALUsrc ? ID_EX_imm_data : b;
        if (ID_EX_ALUop == 2'b01 || (ID_EX_ALUop == 2'b10 && ID_EX_Inst == 4'b1000)) m.res = a - op2;
        else if (ID_EX_ALUop == 2'b10 && ID_EX_Inst == 4'b0111) m.res = a & op2;
        else if (ID_EX_ALUop == 2'b10 && ID_EX_Inst == 4'b0110) m.res = a | op2;
        else m.res = a + op2;
        case (ID_EX_Inst[2:0])
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ($signed(a) < $signed(b));
            3'b101:  c = !($signed(a) < $signed(b));
            default: c = 1'b0;
        endcase
        m.zero  = (m.res == 64'd0);
        m.wd    = b;
        m.tgt   = ID_EX_PC_Out + {ID_EX_imm_data[62:0], 1'b0};
        m.taken = ID_EX_Branch && c;
        m.rd    = ID_EX_rd;
        m.ctl   = {ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_MemtoReg};
        if (flush) m = '0;
        return m;
    endfunction

    task automatic push();
        e = model();
        sb.push_back(e);
        last_e = e;
    endtask

    task automatic step_pop();
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic idle();
        ID_EX_Inst = 4'd0; ID_EX_rs1 = 5'd0; ID_EX_rs2 = 5'd0; ID_EX_rd = 5'd0;
        ID_EX_PC_Out = 64'd0; ID_EX_ReadData1 = 64'd0; ID_EX_ReadData2 = 64'd0; ID_EX_imm_data = 64'd0;
        ID_EX_ALUop = 2'b00; ID_EX_ALUsrc = 1'b0; ID_EX_Branch = 1'b0; ID_EX_MemRead = 1'b0;
        ID_EX_MemWrite = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_MemtoReg = 1'b0;
        MEM_WB_rd = 5'd0; MEM_WB_RegWrite = 1'b0; MEM_WB_WriteData = 64'd0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_initial: got %h expected 0", got); end
        @(posedge clk); #1;
        reset = 1'b1;
        last_e = '0;
        ID_EX_ReadData1 = 64'd5; ID_EX_ReadData2 = 64'd6; ID_EX_rd = 5'd4; ID_EX_RegWrite = 1'b1;
        push();
        step_pop();
        n_checks++;
        if (EX_MEM_ALU_Result !== 64'd11 || EX_MEM_rd !== 5'd4 || EX_MEM_RegWrite !== 1'b1) begin
            n_fail++; $display("FAIL first_capture: got res=%h rd=%0d rw=%b expected res=b rd=4 rw=1",
                               EX_MEM_ALU_Result, EX_MEM_rd, EX_MEM_RegWrite);
        end
        ID_EX_Branch = 1'b1; ID_EX_PC_Out = 64'h40; ID_EX_MemRead = 1'b1;
        push();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", got); end
        sb.delete();
        last_e = '0;
        @(posedge clk); #1;
        n_checks++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_hold: got %h expected 0", got); end
        reset = 1'b1;
        idle();
    endtask

    task automatic test_rtype();
        idle();
        ID_EX_ALUop = 2'b10; ID_EX_rs1 = 5'd6; ID_EX_rs2 = 5'd7; ID_EX_rd = 5'd8; ID_EX_RegWrite = 1'b1;
        ID_EX_ReadData1 = 64'hF0; ID_EX_ReadData2 = 64'h3C;
        for (int i = 0; i < 4; i++) begin
            ID_EX_Inst = rt_inst[i];
            push();
            step_pop();
            n_checks++;
            if (EX_MEM_ALU_Result !== rt_res[i] || EX_MEM_rd !== 5'd8 || EX_MEM_Zero !== 1'b0) begin
                n_fail++; $display("FAIL rtype_%b: got res=%h rd=%0d zero=%b expected res=%h rd=8 zero=0",
                                   rt_inst[i], EX_MEM_ALU_Result, EX_MEM_rd, EX_MEM_Zero, rt_res[i]);
            end
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL rtype_entry: got %h expected %h", got, e); end
        end
    endtask

    task automatic test_forwarding();
        idle();
        ID_EX_ReadData1 = 64'h11; ID_EX_rd = 5'd5; ID_EX_RegWrite = 1'b1;
        push(); step_pop();
        idle();
        ID_EX_rs1 = 5'd5; ID_EX_ReadData1 = 64'h99; ID_EX_ALUsrc = 1'b1; ID_EX_rd = 5'd5;
        MEM_WB_rd = 5'd5; MEM_WB_RegWrite = 1'b1; MEM_WB_WriteData = 64'h22;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_ALU_Result !== 64'h11) begin
            n_fail++; $display("FAIL fwd_exmem_priority: got %h expected 11", EX_MEM_ALU_Result);
        end
        ID_EX_rd = 5'd0; ID_EX_RegWrite = 1'b1;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_ALU_Result !== 64'h22) begin
            n_fail++; $display("FAIL fwd_memwb: got %h expected 22", EX_MEM_ALU_Result);
        end
        ID_EX_rs1 = 5'd0; MEM_WB_rd = 5'd0; ID_EX_rd = 5'd5;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_ALU_Result !== 64'h99) begin
            n_fail++; $display("FAIL fwd_rs0: got %h expected 99", EX_MEM_ALU_Result);
        end
        ID_EX_rs2 = 5'd5; ID_EX_ReadData2 = 64'h44; MEM_WB_rd = 5'd5;
        ID_EX_MemWrite = 1'b1; ID_EX_RegWrite = 1'b0; ID_EX_rd = 5'd0;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_WriteData !== 64'h99 || EX_MEM_MemWrite !== 1'b1) begin
            n_fail++; $display("FAIL fwd_store_data: got wd=%h mw=%b expected wd=99 mw=1",
                               EX_MEM_WriteData, EX_MEM_MemWrite);
        end
    endtask

    task automatic test_branch();
        idle();
        ID_EX_ALUop = 2'b01; ID_EX_Branch = 1'b1; ID_EX_PC_Out = 64'h100; ID_EX_imm_data = 64'h8;
        ID_EX_rs1 = 5'd3; ID_EX_ReadData1 = 64'h77; ID_EX_ReadData2 = 64'h55;
        MEM_WB_rd = 5'd3; MEM_WB_RegWrite = 1'b1; MEM_WB_WriteData = 64'h55;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_Branch_Target !== 64'h110 || EX_MEM_BranchTaken !== 1'b1) begin
            n_fail++; $display("FAIL beq_fwd: got tgt=%h taken=%b expected tgt=110 taken=1",
                               EX_MEM_Branch_Target, EX_MEM_BranchTaken);
        end
        ID_EX_rs1 = 5'd0; MEM_WB_RegWrite = 1'b0;
        ID_EX_ReadData1 = 64'hFFFF_FFFF_FFFF_FFFF; ID_EX_ReadData2 = 64'd1;
        ID_EX_Inst = 4'b0100;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_BranchTaken !== 1'b1) begin
            n_fail++; $display("FAIL blt_signed: got %b expected 1", EX_MEM_BranchTaken);
        end
        ID_EX_Inst = 4'b0101;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_BranchTaken !== 1'b0) begin
            n_fail++; $display("FAIL bge_signed: got %b expected 0", EX_MEM_BranchTaken);
        end
        ID_EX_Inst = 4'b0001; ID_EX_ReadData1 = 64'd7; ID_EX_ReadData2 = 64'd7;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_BranchTaken !== 1'b0) begin
            n_fail++; $display("FAIL bne_equal: got %b expected 0", EX_MEM_BranchTaken);
        end
        ID_EX_Inst = 4'b0000; ID_EX_Branch = 1'b0;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_BranchTaken !== 1'b0 || EX_MEM_Zero !== 1'b1) begin
            n_fail++; $display("FAIL beq_no_branch: got taken=%b zero=%b expected taken=0 zero=1",
                               EX_MEM_BranchTaken, EX_MEM_Zero);
        end
    endtask

    task automatic test_flush();
        idle();
        ID_EX_MemWrite = 1'b1; ID_EX_rd = 5'd9; ID_EX_Branch = 1'b1; ID_EX_PC_Out = 64'h200;
        ID_EX_ReadData1 = 64'h33; ID_EX_ReadData2 = 64'h33; flush = 1'b1;
        push(); step_pop();
        n_checks++;
        if ({EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg} !== 4'b0000 ||
            EX_MEM_rd !== 5'd0 || EX_MEM_BranchTaken !== 1'b0) begin
            n_fail++; $display("FAIL flush_ctrl: got ctl=%b rd=%0d taken=%b expected 0",
                               {EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg},
                               EX_MEM_rd, EX_MEM_BranchTaken);
        end
        n_checks++;
        if (EX_MEM_ALU_Result !== 64'd0 || EX_MEM_WriteData !== 64'd0 || EX_MEM_Branch_Target !== 64'd0) begin
            n_fail++; $display("FAIL flush_data: got res=%h wd=%h tgt=%h expected 0",
                               EX_MEM_ALU_Result, EX_MEM_WriteData, EX_MEM_Branch_Target);
        end
        idle();
        ID_EX_ReadData1 = 64'd3; ID_EX_ReadData2 = 64'd4; ID_EX_rd = 5'd9;
        ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_MemtoReg = 1'b1;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_ALU_Result !== 64'd7 || EX_MEM_rd !== 5'd9 ||
            {EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg} !== 4'b1011) begin
            n_fail++; $display("FAIL after_flush: got res=%h rd=%0d expected res=7 rd=9 ctl=1011",
                               EX_MEM_ALU_Result, EX_MEM_rd);
        end
    endtask

    task automatic test_wrap();
        idle();
        ID_EX_ReadData1 = 64'hFFFF_FFFF_FFFF_FFFF; ID_EX_ALUsrc = 1'b1; ID_EX_imm_data = 64'd1;
        push(); step_pop();
        n_checks++;
        if (EX_MEM_ALU_Result !== 64'd0 || EX_MEM_Zero !== 1'b1) begin
            n_fail++; $display("FAIL wrap_add: got res=%h zero=%b expected res=0 zero=1",
                               EX_MEM_ALU_Result, EX_MEM_Zero);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            ID_EX_Inst = 4'($urandom);
            ID_EX_rs1 = 5'($urandom_range(0, 3)); ID_EX_rs2 = 5'($urandom_range(0, 3));
            ID_EX_rd = 5'($urandom_range(0, 3));
            ID_EX_PC_Out = {$urandom, $urandom};
            ID_EX_ReadData1 = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            ID_EX_ReadData2 = ($urandom_range(0, 3) == 0) ? ID_EX_ReadData1 : {$urandom, $urandom};
            ID_EX_imm_data = {$urandom, $urandom};
            ID_EX_ALUop = 2'($urandom); ID_EX_ALUsrc = 1'($urandom); ID_EX_Branch = 1'($urandom);
            ID_EX_MemRead = 1'($urandom); ID_EX_MemWrite = 1'($urandom);
            ID_EX_RegWrite = 1'($urandom); ID_EX_MemtoReg = 1'($urandom);
            MEM_WB_rd = 5'($urandom_range(0, 3)); MEM_WB_RegWrite = 1'($urandom);
            MEM_WB_WriteData = {$urandom, $urandom};
            flush = ($urandom_range(0, 7) == 0);
            push(); step_pop();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL b2b_%0d: got %h expected %h", i, got, e); end
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_e   = '0;
        test_reset();
        test_rtype();
        test_forwarding();
        test_branch();
        test_flush();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV64 pipeline, directly downstream of the ID/EX pipeline register. Takes the ID/EX register outputs, resolves operand forwarding from EX/MEM and MEM/WB, decodes ALU control, computes the ALU result, branch target and branch decision, and captures everything in the EX/MEM pipeline register. Supports a flush input that turns the captured entry into a bubble.

## Interface
Parameters:
- XLEN, 64, datapath width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- ID_EX_Inst  in  4  {funct7[5], funct3}
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  in  5 each  register indices
- ID_EX_PC_Out  in  XLEN  PC of the instruction
- ID_EX_ReadData1, ID_EX_ReadData2  in  XLEN  register file operands
- ID_EX_imm_data  in  XLEN  sign-extended immediate
- ID_EX_ALUop  in  2  ALU op class
- ID_EX_ALUsrc, ID_EX_Branch, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_MemtoReg  in  1 each  control
- MEM_WB_rd  in  5  write-back destination
- MEM_WB_RegWrite  in  1  write-back enable
- MEM_WB_WriteData  in  XLEN  write-back value
- flush  in  1  squash the instruction being captured
- EX_MEM_ALU_Result  out  XLEN  registered ALU result
- EX_MEM_Zero  out  1  registered (ALU result == 0)
- EX_MEM_WriteData  out  XLEN  registered forwarded rs2 value (store data)
- EX_MEM_Branch_Target  out  XLEN  registered PC + (imm << 1)
- EX_MEM_BranchTaken  out  1  registered Branch AND condition met
- EX_MEM_rd  out  5  registered destination
- EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg  out  1 each  registered control

## Operation
- Forwarding, per operand (A from rs1, B from rs2), priority high to low:
  - EX_MEM_RegWrite=1, EX_MEM_rd!=0, EX_MEM_rd==rsX -> EX_MEM_ALU_Result
  - MEM_WB_RegWrite=1, MEM_WB_rd!=0, MEM_WB_rd==rsX -> MEM_WB_WriteData
  - otherwise ID_EX_ReadDataX
- ALU operand 2 = ID_EX_imm_data if ALUsrc=1, else forwarded B. Store data is always forwarded B.
- ALU control:
  - ALUop 00 -> ADD
  - ALUop 01 -> SUB
  - ALUop 10 -> decode Inst: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR; any other code -> ADD
  - ALUop 11 -> ADD
- Arithmetic is modulo 2^XLEN: wrap-around, no overflow flag.
- Branch condition from Inst[2:0] (funct3), evaluated on the forwarded operands A and B:
  - 000 BEQ: A==B
  - 001 BNE: A!=B
  - 100 BLT: signed A<B
  - 101 BGE: signed A>=B
  - any other funct3: not taken
- BranchTaken = ID_EX_Branch AND condition.
- Branch target = ID_EX_PC_Out + (ID_EX_imm_data << 1), truncated to XLEN.
- Flush: on a clock edge with flush=1, MemRead, MemWrite, RegWrite, MemtoReg and BranchTaken are captured as 0, and rd is captured as 0. Data fields are also captured as 0.

## Timing
- Reset (reset=0): every output goes to 0 immediately, without waiting for clk, and stays 0 while reset=0.
- First capture happens on the first rising edge after reset returns to 1.
- Latency: one cycle. ID/EX values present before edge N appear on the EX_MEM_* outputs after edge N.
- Forwarding sources are sampled combinationally in the same cycle. The EX/MEM source is this block's own registered outputs.
- Same rd in both EX/MEM and MEM/WB: EX/MEM wins.
- rd==0 never forwards, even when RegWrite=1.
- flush and a valid ID/EX instruction on the same edge: flush wins.
- reset asserted mid-stream: the entry in flight is discarded. Nothing is retained across reset.

## Test plan
- Reset: drive reset=0 mid-cycle with nonzero state -> all outputs read 0 before the next clk edge; after release, first edge captures normally.
- R-type AND/OR/SUB/ADD: A=0xF0, B=0x3C, no hazards, ALUop=10:
  - Inst=0111 -> ALU_Result=0x30
  - Inst=0110 -> 0xFC
  - Inst=1000 -> 0xB4
  - Inst=0000 -> 0x12C
  - each appears one cycle later
- Forwarding priority: rs1=5, EX_MEM_rd=5 holding 0x11, MEM_WB_rd=5 with WriteData 0x22 -> A=0x11. With EX_MEM_RegWrite=0 -> A=0x22. With rs1=0 -> ReadData1 used.
- Branch: PC=0x100, imm=0x8, BEQ with forwarded A==B -> Branch_Target=0x110, BranchTaken=1. BLT with A=-1, B=1 -> taken. BGE with the same operands -> not taken.
- Flush: valid store (MemWrite=1) with flush=1 -> all control and rd outputs 0 after the edge. Next instruction with flush=0 is captured normally.
- Wrap: ADD of 0xFFFF_FFFF_FFFF_FFFF + 1 -> ALU_Result=0, Zero=1.
